// File: rtl/add_sub_sat_pipe_pkg.sv
// add_sub_pkg: Q-format constants, opcodes and saturation limits shared by add_sub_sat_pipe.
// Revision 1.0
`default_nettype none

package add_sub_pkg;

  localparam int Q_N    = 32;
  localparam int Q_FRAC = 24;

  // Widest operand the limit helpers support.
  localparam int MAX_W  = 64;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic logic [MAX_W-1:0] sat_max(input int n);
    sat_max = (MAX_W'(1) << (n - 1)) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int n);
    sat_min = MAX_W'(1) << (n - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_sub_sat_pipe_stage.sv
// pipe_reg_stage: one valid/ready register slice carrying {result, ovf}.
// Revision 1.0
`default_nettype none

module pipe_reg_stage
  import add_sub_pkg::*;
#(
  parameter int N = Q_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic         in_ovf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_ovf
);

  logic         valid_r;
  logic [N-1:0] result_r;
  logic         ovf_r;

  // Load when empty or when the current entry leaves this same edge.
  assign in_ready = !valid_r || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        result_r <= in_result;
        ovf_r    <= in_ovf;
      end
    end
  end

  assign out_valid  = valid_r;
  assign out_result = result_r;
  assign out_ovf    = ovf_r;

endmodule

`default_nettype wire

// File: rtl/add_sub_sat_pipe.sv
// add_sub_sat_pipe: pipelined signed add/sub with optional saturation and valid/ready flow control.
// Revision 1.0
`default_nettype none

module add_sub_sat_pipe
  import add_sub_pkg::*;
#(
  parameter int N      = Q_N,
  parameter int FRAC   = Q_FRAC,
  parameter int STAGES = 2,
  parameter int SAT    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         a_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf
);

  if (STAGES < 1 || STAGES > 4 || FRAC < 0 || FRAC >= N || N > MAX_W) begin : g_param_check
    $error("add_sub_sat_pipe: illegal parameter set");
  end

  localparam logic [N-1:0] MAX_VAL = N'(sat_max(N));
  localparam logic [N-1:0] MIN_VAL = N'(sat_min(N));

  logic [N:0]   wide_x;
  logic [N:0]   wide_y;
  logic [N:0]   wide_sum;
  logic         sum_ovf;
  logic [N-1:0] sum_res;

  always_comb begin
    wide_x   = {X[N-1], X};
    wide_y   = {Y[N-1], Y};
    wide_sum = (a_s == OP_SUB) ? (wide_x - wide_y) : (wide_x + wide_y);
    // The extra sign bit disagrees with the top result bit only on overflow.
    sum_ovf  = wide_sum[N] ^ wide_sum[N-1];
    sum_res  = wide_sum[N-1:0];
    if (SAT != 0 && sum_ovf) begin
      sum_res = wide_sum[N] ? MIN_VAL : MAX_VAL;
    end
  end

  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [N-1:0]    dat_res [STAGES+1];
  logic [STAGES:0] dat_ovf;

  assign vld[0]      = in_valid;
  assign dat_res[0]  = sum_res;
  assign dat_ovf[0]  = sum_ovf;
  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_reg_stage #(
      .N(N)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[k]),
      .in_ready  (rdy[k]),
      .in_result (dat_res[k]),
      .in_ovf    (dat_ovf[k]),
      .out_valid (vld[k+1]),
      .out_ready (rdy[k+1]),
      .out_result(dat_res[k+1]),
      .out_ovf   (dat_ovf[k+1])
    );
  end

  assign out_valid = vld[STAGES];
  assign result    = dat_res[STAGES];
  assign ovf       = dat_ovf[STAGES];

endmodule

`default_nettype wire

// File: tb/tb_add_sub_sat_pipe.sv
// tb_add_sub_sat_pipe: vector table, backpressure, throughput and reset checks on four configurations.
// Revision 1.0
`default_nettype none

module tb_add_sub_sat_pipe;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         a_s = 1'b0;
  logic [N-1:0] X = '0;
  logic [N-1:0] Y = '0;

  logic [3:0]   in_rdy;
  logic [3:0]   o_val;
  logic [3:0]   o_ovf;
  logic [N-1:0] o_res [4];

  int checks = 0;
  int failures = 0;
  int out_cnt [4] = '{0, 0, 0, 0};

  logic [N:0] sb [4][$];
  logic       stall_prev [4] = '{0, 0, 0, 0};
  logic [N:0] stall_val [4];
  logic [N:0] exp_v;

  always #5 clk = ~clk;

  // 0: STAGES=2 SAT=1, 1: STAGES=2 SAT=0, 2: STAGES=1 SAT=1, 3: STAGES=4 SAT=0
  add_sub_sat_pipe #(.N(N), .FRAC(24), .STAGES(2), .SAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .X(X), .Y(Y), .a_s(a_s),
    .out_valid(o_val[0]), .out_ready(out_ready), .result(o_res[0]), .ovf(o_ovf[0]));
  add_sub_sat_pipe #(.N(N), .FRAC(24), .STAGES(2), .SAT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .X(X), .Y(Y), .a_s(a_s),
    .out_valid(o_val[1]), .out_ready(out_ready), .result(o_res[1]), .ovf(o_ovf[1]));
  add_sub_sat_pipe #(.N(N), .FRAC(24), .STAGES(1), .SAT(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .X(X), .Y(Y), .a_s(a_s),
    .out_valid(o_val[2]), .out_ready(out_ready), .result(o_res[2]), .ovf(o_ovf[2]));
  add_sub_sat_pipe #(.N(N), .FRAC(24), .STAGES(4), .SAT(0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[3]), .X(X), .Y(Y), .a_s(a_s),
    .out_valid(o_val[3]), .out_ready(out_ready), .result(o_res[3]), .ovf(o_ovf[3]));

  function automatic bit sat_of(input int i);
    return (i == 0) || (i == 2);
  endfunction

  // Reference: exact integer arithmetic, then range test and clamp or wrap.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic sub, input bit sat);
    longint sx, sy, r, hi, lo;
    logic o;
    logic [N-1:0] v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = sub ? (sx - sy) : (sx + sy);
    hi = (longint'(1) << (N - 1)) - 1;
    lo = -(longint'(1) << (N - 1));
    o  = (r > hi) || (r < lo);
    v  = N'(r);
    if (o && sat) v = (r > 0) ? N'(hi) : N'(lo);
    return {v, o};
  endfunction

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input bit ok, input string name, input longint got, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge where handshakes are stable.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sb[i].delete();
        stall_prev[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (stall_prev[i]) begin
          checks++;
          if (!o_val[i] || {o_res[i], o_ovf[i]} != stall_val[i]) begin
            failures++;
            $display("FAIL stall_hold dut%0d: valid=%0b got=%h held=%h", i, o_val[i],
                     {o_res[i], o_ovf[i]}, stall_val[i]);
          end
        end
        if (o_val[i] && out_ready) begin
          checks++;
          out_cnt[i]++;
          if (sb[i].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out dut%0d: got=%h expected=none", i, {o_res[i], o_ovf[i]});
          end else begin
            exp_v = sb[i].pop_front();
            if ({o_res[i], o_ovf[i]} != exp_v) begin
              failures++;
              $display("FAIL scoreboard dut%0d: got=%h expected=%h", i, {o_res[i], o_ovf[i]}, exp_v);
            end
          end
        end
        if (in_valid && in_rdy[i]) sb[i].push_back(model(X, Y, a_s, sat_of(i)));
        stall_prev[i] = o_val[i] && !out_ready;
        stall_val[i]  = {o_res[i], o_ovf[i]};
      end
    end
  end

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sub;
    logic [N-1:0] exp_sat;
    logic [N-1:0] exp_wrap;
    logic         exp_ovf;
  } vec_t;

  vec_t         vecs [8];
  logic [N-1:0] bp_x [4];
  logic [N-1:0] bp_y [4];
  int           lat, acc, base [4];
  bit           got, will_acc;

  initial begin
    vecs[0] = '{32'hF5E0_0000, 32'h1400_0000, 1'b0, 32'h09E0_0000, 32'h09E0_0000, 1'b0};
    vecs[1] = '{32'hF5E0_0000, 32'h1400_0000, 1'b1, 32'hE1E0_0000, 32'hE1E0_0000, 1'b0};
    vecs[2] = '{32'h6400_0000, 32'h6400_0000, 1'b0, 32'h7FFF_FFFF, 32'hC800_0000, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h0100_0000, 1'b1, 32'h8000_0000, 32'h7F00_0000, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check(!o_val[i] && o_res[i] == '0 && !o_ovf[i], "reset_outputs", {o_val[i], o_res[i], o_ovf[i]}, 0);
      check(in_rdy[i] == 1'b1, "reset_in_ready", in_rdy[i], 1);
    end

    // Directed vectors, one at a time, with latency measured on the STAGES=2 instances.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      X = vecs[k].x; Y = vecs[k].y; a_s = vecs[k].sub; in_valid = 1'b1;
      lat = 0; got = 0;
      while (lat < 10 && !got) begin
        @(posedge clk);
        lat++;
        #1 in_valid = 1'b0;
        if (o_val[0]) got = 1;
      end
      check(lat == 2, "vec_latency", lat, 2);
      check({o_res[0], o_ovf[0]} == {vecs[k].exp_sat, vecs[k].exp_ovf}, "vec_sat",
            {o_res[0], o_ovf[0]}, {vecs[k].exp_sat, vecs[k].exp_ovf});
      check(o_val[1] && {o_res[1], o_ovf[1]} == {vecs[k].exp_wrap, vecs[k].exp_ovf}, "vec_wrap",
            {o_val[1], o_res[1], o_ovf[1]}, {1'b1, vecs[k].exp_wrap, vecs[k].exp_ovf});
    end

    // Backpressure: STAGES=2 holds exactly two entries while stalled.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bp_x[i] = rnd_op();
      bp_y[i] = rnd_op();
    end
    base[0] = out_cnt[0];
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 4);
      X = bp_x[acc % 4]; Y = bp_y[acc % 4]; a_s = acc[0];
      #1 will_acc = in_valid && in_rdy[0];
      @(posedge clk);
      #1 if (will_acc) acc++;
    end
    check(acc == 2, "bp_accepted", acc, 2);
    check(in_rdy[0] == 1'b0, "bp_in_ready", in_rdy[0], 0);
    check(o_val[0] == 1'b1, "bp_out_valid", o_val[0], 1);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      in_valid = 1'b1;
      X = bp_x[acc]; Y = bp_y[acc]; a_s = acc[0];
      #1 will_acc = in_rdy[0];
      @(posedge clk);
      #1 if (will_acc) acc++;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check(out_cnt[0] - base[0] == 4, "bp_drained", out_cnt[0] - base[0], 4);

    // Back-to-back: 16 operands, one per cycle, on every configuration.
    for (int i = 0; i < 4; i++) base[i] = out_cnt[i];
    for (int k = 0; k < 16; k++) begin
      X = rnd_op(); Y = rnd_op(); a_s = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check(out_cnt[i] - base[i] == 16, "b2b_count", out_cnt[i] - base[i], 16);

    // Random traffic with random backpressure, checked by the scoreboard.
    for (int c = 0; c < 300; c++) begin
      X = rnd_op(); Y = rnd_op(); a_s = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check(sb[i].size() == 0, "random_drain", sb[i].size(), 0);

    // Reset with two entries in flight.
    out_ready = 1'b0;
    in_valid = 1'b1;
    X = 32'h1234_5678; Y = 32'h0100_0000; a_s = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    check(o_val[0] == 1'b1, "pre_reset_in_flight", o_val[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check(!o_val[i] && o_res[i] == '0 && !o_ovf[i], "midreset_outputs", {o_val[i], o_res[i], o_ovf[i]}, 0);
      check(in_rdy[i] == 1'b1, "midreset_in_ready", in_rdy[i], 1);
    end
    base[0] = out_cnt[0];
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check(out_cnt[0] == base[0], "midreset_no_output", out_cnt[0] - base[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/add_sub_sat_pipe.md
Name: add_sub_sat_pipe

Overview:
- Parametrised, pipelined fixed-point adder/subtractor for the CORDIC datapath. Default format is Q8.24, signed two's complement.
- Adds optional saturation, an overflow flag and a valid/ready handshake on both sides, so CORDIC iteration stages can stall without losing data.
- Sits between the angle/coordinate registers and the shift-add micro-rotation logic.

Parameters:
- N, 32: operand and result width in bits.
- FRAC, 24: fractional bits. Used only for documentation and package constants; the arithmetic is format-agnostic.
- STAGES, 2: pipeline depth, legal range 1..4. This is also the latency in cycles.
- SAT, 1: 1 = saturate on overflow; 0 = wrap (modulo 2^N).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands this cycle.
- X  in  N  signed operand A.
- Y  in  N  signed operand B.
- a_s  in  1  0 = X+Y, 1 = X-Y.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  N  signed sum/difference.
- ovf  out  1  overflow occurred for this result; qualified by out_valid.

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high on rst, sampled on the rising edge of clk.
- Reset: all stage valid bits clear; result=0, ovf=0, out_valid=0. Operands presented while rst=1 are discarded. In the first cycle after rst deasserts, in_ready=1.
- Transfers:
  - Input transfer on an edge with in_valid && in_ready.
  - Output transfer on an edge with out_valid && out_ready.
- Arithmetic (stage 0):
  - Sign-extend X and Y to N+1 bits; compute X+Y or X-Y at N+1 bits.
  - Overflow when bits [N] and [N-1] of the wide result differ.
  - SAT=1 with overflow: result = 0x7FF..F if the wide result is positive, 0x800..0 if negative.
  - SAT=0: result = the low N bits.
  - ovf is reported regardless of SAT.
- Pipeline:
  - STAGES register stages, each holding {valid, result, ovf}. Stage 0 registers the arithmetic output; stages 1..STAGES-1 are pure delay.
  - Stage k loads when it is empty, or when it is draining in the same cycle (stage k+1 loads, or for the last stage an output transfer occurs).
  - in_ready = !valid[0] || stage 0 draining. This is combinational from state and out_ready; there is no combinational path from in_valid.
  - Bubbles collapse: an empty stage accepts even while a later stage is stalled.
- Latency and throughput:
  - With out_ready held high, a result appears exactly STAGES cycles after acceptance.
  - Throughput is 1 per cycle. Capacity is STAGES entries.
- Stall: while out_valid=1 and out_ready=0, result and ovf are held stable. No entry is dropped, duplicated or reordered.
- Simultaneous events:
  - A full pipeline with out_ready=1 and in_valid=1 accepts a new operand in the same cycle it emits a result.
  - rst overrides all handshakes.
- Reset mid-operation: all in-flight entries are discarded. out_valid=0 from the next cycle, with no partial results emitted.
- Boundary operands:
  - 0x800..0 - 0x800..0 = 0, ovf=0.
  - 0 - 0x800..0 overflows: saturates to 0x7FF..F (SAT=1) or wraps to 0x800..0 (SAT=0).

Decomposition:
- Package add_sub_pkg:
  - Q-format constants (default N, FRAC).
  - Saturation limit constants/functions sat_max(N) and sat_min(N).
  - Opcode constants OP_ADD=0, OP_SUB=1.
- Sub-module pipe_reg_stage: one valid/ready register slice carrying {result, ovf}, parametrised on N. It is instantiated STAGES times in a generate loop.
- The arithmetic stays in the top level.

Test Plan:
- Basic add/sub (Q8.24, SAT=1, STAGES=2, out_ready=1):
  - X=0xF5E00000 (-10.125), Y=0x14000000 (20.0), a_s=0 -> result 0x09E00000 (9.875), ovf=0, 2 cycles later.
  - Same operands with a_s=1 -> result 0xE1E00000 (-30.125), ovf=0.
- Positive overflow: X=Y=0x64000000 (100.0), a_s=0:
  - SAT=1 -> 0x7FFFFFFF, ovf=1.
  - SAT=0 -> 0xC8000000, ovf=1.
- Negative overflow: X=0x80000000, Y=0x01000000, a_s=1, SAT=1 -> 0x80000000, ovf=1. Separately, X=0, Y=0x80000000, a_s=1 -> 0x7FFFFFFF, ovf=1.
- Backpressure (STAGES=2):
  - Hold out_ready=0 and stream 4 operands -> only 2 accepted, then in_ready=0.
  - Release out_ready -> 4 results in order, no gaps beyond pipeline fill, out_valid/result stable during the stall.
- Back-to-back throughput: 16 random operand pairs with out_ready=1, for STAGES=1 and STAGES=4 -> one result per cycle, each matching the reference model including ovf.
- Reset mid-stream: assert rst for 1 cycle with 2 entries in flight -> out_valid=0 the next cycle, those entries never appear, in_ready=1 the cycle after rst deasserts.
